id_issue_scheduler: RTL and testbench

In-order issue controller between the ID decode logic and the ID/EXE pipeline register. It keeps a per-register scoreboard of in-flight writes, withholds dispatch while an operand or destination hazard exists, and serializes syscall/LL/SC instructions. Serialization drains the pipeline, dispatches the instruction, pulses `SYS`, then holds a fixed bubble. Its outputs drive the ID freeze and dispatch-enable logic.

---
 rtl/id_sched_pkg.sv | 16 +
 rtl/id_issue_scheduler_sb_entry.sv | 29 ++
 rtl/id_issue_scheduler.sv | 158 +++++++++++++++
 tb/tb_id_issue_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_sched_pkg.sv
// Shared types and widths for the ID issue scheduler.
package id_sched_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned PEND_W    = 7;
  localparam int unsigned HOLD_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/id_issue_scheduler_sb_entry.sv
// One scoreboard counter: in-flight writes to a single architectural register.
module sb_entry
  import id_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow_c
);

  // A retire against an empty counter is flagged and otherwise ignored.
  assign underflow_c = dec && !inc && (count == '0);

  // Counter update; simultaneous inc and dec cancel.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_issue_scheduler.sv
// In-order issue controller: register scoreboard, hazard stall, serialize FSM.
// Optional build macro: SCOREBOARD_BYPASS_EN (same-cycle retire bypass).
module id_issue_scheduler
  import id_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  Instr_Valid_IN,
  input  logic [REG_IDX_W-1:0]  SrcA_IN,
  input  logic                  SrcA_Used_IN,
  input  logic [REG_IDX_W-1:0]  SrcB_IN,
  input  logic                  SrcB_Used_IN,
  input  logic [REG_IDX_W-1:0]  Dest_IN,
  input  logic                  RegWrite_IN,
  input  logic                  Serialize_IN,
  input  logic                  Flush_IN,
  input  logic [REG_IDX_W-1:0]  WriteRegister1_IN,
  input  logic                  RegWrite1_IN,
  output logic                  Dispatch_OUT,
  output logic                  WANT_FREEZE,
  output logic                  SYS,
  output logic [PEND_W-1:0]     Pending_Count_OUT,
  output logic [NUM_REGS-1:0]   Busy_Mask_OUT,
  output logic                  Underflow_ERR
);

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  sched_state_e state, state_nx;
  logic [HOLD_W-1:0] hold_q;

  logic [CNT_W-1:0]       cnt     [1:NUM_REGS-1];
  logic [CNT_W-1:0]       cnt_eff [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]    inc_v, dec_v, uf_v, busy_v;
  logic [CNT_W-1:0]       cnt_a, cnt_b, cnt_d;
  logic                   hazard_c, drain_ok_c, disp_wr_c, pend_inc_c, pend_dec_c;

  // Per-register counters for r1..r31; r0 is never tracked.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    sb_entry #(.CNT_W(CNT_W)) u_sb (
      .CLK         (CLK),
      .RESET       (RESET),
      .inc         (inc_v[r]),
      .dec         (dec_v[r]),
      .count       (cnt[r]),
      .underflow_c (uf_v[r])
    );
  end

  // Retire decode, busy flags and the counter view used for hazard checks.
  always_comb begin
    dec_v  = '0;
    busy_v = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      dec_v[r]  = RegWrite1_IN && (WriteRegister1_IN == REG_IDX_W'(r));
      busy_v[r] = (cnt[r] != '0);
`ifdef SCOREBOARD_BYPASS_EN
      cnt_eff[r] = cnt[r] - CNT_W'(dec_v[r] && busy_v[r]);
`else
      cnt_eff[r] = cnt[r];
`endif
    end
  end

  // Operand/destination lookup and hazard reduction; r0 reads as empty.
  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    cnt_d = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (SrcA_IN == REG_IDX_W'(r)) cnt_a = cnt_eff[r];
      if (SrcB_IN == REG_IDX_W'(r)) cnt_b = cnt_eff[r];
      if (Dest_IN == REG_IDX_W'(r)) cnt_d = cnt_eff[r];
    end
    hazard_c = (SrcA_Used_IN && (cnt_a != '0)) ||
               (SrcB_Used_IN && (cnt_b != '0)) ||
               (RegWrite_IN  && (cnt_d == CNT_W'(CNT_MAX)));
  end

  // Drain completes once no writes remain in flight.
`ifdef SCOREBOARD_BYPASS_EN
  assign drain_ok_c = (Pending_Count_OUT == PEND_W'(|(dec_v & busy_v)));
`else
  assign drain_ok_c = (Pending_Count_OUT == '0);
`endif

  // Dispatch-side increments into the scoreboard.
  always_comb begin
    disp_wr_c = Dispatch_OUT && RegWrite_IN && (Dest_IN != '0);
    inc_v     = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      inc_v[r] = disp_wr_c && (Dest_IN == REG_IDX_W'(r));
    end
  end

  // A retire only reduces the total when it actually decrements or cancels an increment.
  assign pend_inc_c = disp_wr_c;
  assign pend_dec_c = |(dec_v & (busy_v | inc_v));

  assign Busy_Mask_OUT = {busy_v, 1'b0};
  assign WANT_FREEZE   = Instr_Valid_IN && !Dispatch_OUT && !Flush_IN;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (Instr_Valid_IN && Serialize_IN && !Flush_IN) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (Flush_IN)        state_nx = ST_IDLE;
        else if (drain_ok_c) state_nx = ST_ISSUE;
      end
      ST_ISSUE: state_nx = ST_HOLD;
      ST_HOLD:  if (hold_q <= HOLD_W'(1)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM output logic: same-cycle dispatch decision.
  always_comb begin
    Dispatch_OUT = 1'b0;
    case (state)
      ST_IDLE:  Dispatch_OUT = Instr_Valid_IN && !hazard_c && !Serialize_IN && !Flush_IN;
      ST_ISSUE: Dispatch_OUT = 1'b1;
      default:  Dispatch_OUT = 1'b0;
    endcase
  end

  // Post-serialize bubble counter.
  always_ff @(posedge CLK) begin
    if (!RESET)                 hold_q <= '0;
    else if (state == ST_ISSUE) hold_q <= HOLD_W'(HOLD_CYCLES);
    else if (state == ST_HOLD)  hold_q <= hold_q - HOLD_W'(1);
  end

  // Syscall pulse, sticky underflow and running in-flight total.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      SYS               <= 1'b0;
      Underflow_ERR     <= 1'b0;
      Pending_Count_OUT <= '0;
    end else begin
      SYS <= (state == ST_ISSUE);
      if (|uf_v) Underflow_ERR <= 1'b1;
      if (pend_inc_c && !pend_dec_c)      Pending_Count_OUT <= Pending_Count_OUT + PEND_W'(1);
      else if (pend_dec_c && !pend_inc_c) Pending_Count_OUT <= Pending_Count_OUT - PEND_W'(1);
    end
  end

endmodule

// File: tb/tb_id_issue_scheduler.sv
// Self-checking bench for id_issue_scheduler: vector table, corner sequences, random vs model.
module tb_id_issue_scheduler;

  localparam int unsigned HOLD = 2;
  localparam int CNT_MAX = 3;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int ISSUE_IDX = BYP ? 3 : 4;

  typedef struct {
    bit       valid;
    bit [4:0] sa;
    bit       sau;
    bit [4:0] sb;
    bit       sbu;
    bit [4:0] dst;
    bit       rw;
    bit       ser;
    bit       fl;
    bit [4:0] wr;
    bit       rwr;
  } vin_t;

  typedef struct {
    vin_t        in;
    bit          e_disp;
    bit          e_frz;
    int          e_pend;
    logic [31:0] e_busy;
  } vec_t;

  logic        CLK, RESET;
  logic        Instr_Valid_IN, SrcA_Used_IN, SrcB_Used_IN, RegWrite_IN;
  logic        Serialize_IN, Flush_IN, RegWrite1_IN;
  logic [4:0]  SrcA_IN, SrcB_IN, Dest_IN, WriteRegister1_IN;
  logic        Dispatch_OUT, WANT_FREEZE, SYS, Underflow_ERR;
  logic [6:0]  Pending_Count_OUT;
  logic [31:0] Busy_Mask_OUT;

  id_issue_scheduler #(.CNT_W(2), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr_Valid_IN(Instr_Valid_IN),
    .SrcA_IN(SrcA_IN), .SrcA_Used_IN(SrcA_Used_IN),
    .SrcB_IN(SrcB_IN), .SrcB_Used_IN(SrcB_Used_IN),
    .Dest_IN(Dest_IN), .RegWrite_IN(RegWrite_IN),
    .Serialize_IN(Serialize_IN), .Flush_IN(Flush_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .RegWrite1_IN(RegWrite1_IN),
    .Dispatch_OUT(Dispatch_OUT), .WANT_FREEZE(WANT_FREEZE), .SYS(SYS),
    .Pending_Count_OUT(Pending_Count_OUT), .Busy_Mask_OUT(Busy_Mask_OUT),
    .Underflow_ERR(Underflow_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: plain integer counters and a phase description of serialization.
  int m_cnt [32];
  bit m_uf, m_sys, m_drain, m_issue;
  int m_bub;
  bit e_disp;

  vec_t tbl [19];

  function automatic vin_t mk(bit v, bit [4:0] sa, bit sau, bit [4:0] sb, bit sbu,
                              bit [4:0] dst, bit rw, bit [4:0] wr, bit rwr);
    vin_t x;
    x.valid = v; x.sa = sa; x.sau = sau; x.sb = sb; x.sbu = sbu;
    x.dst = dst; x.rw = rw; x.ser = 1'b0; x.fl = 1'b0; x.wr = wr; x.rwr = rwr;
    return x;
  endfunction

  function automatic vec_t row(vin_t in, bit d, bit f, int p, logic [31:0] b);
    vec_t x;
    x.in = in; x.e_disp = d; x.e_frz = f; x.e_pend = p; x.e_busy = b;
    return x;
  endfunction

  task automatic apply(input vin_t v);
    Instr_Valid_IN = v.valid;
    SrcA_IN = v.sa; SrcA_Used_IN = v.sau;
    SrcB_IN = v.sb; SrcB_Used_IN = v.sbu;
    Dest_IN = v.dst; RegWrite_IN = v.rw;
    Serialize_IN = v.ser; Flush_IN = v.fl;
    WriteRegister1_IN = v.wr; RegWrite1_IN = v.rwr;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Count seen by hazard/drain logic: a live retire is discounted only with bypass.
  function automatic int eff_cnt(int r);
    int c;
    c = m_cnt[r];
    if (r != 0 && BYP && RegWrite1_IN && int'(WriteRegister1_IN) == r && c > 0) c = c - 1;
    return c;
  endfunction

  function automatic int m_pending();
    int s = 0;
    for (int r = 1; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) b[r] = 1'b1;
    return b;
  endfunction

  function automatic bit exp_dispatch();
    bit hz = 1'b0;
    if (SrcA_Used_IN && SrcA_IN != 0 && eff_cnt(int'(SrcA_IN)) > 0) hz = 1'b1;
    if (SrcB_Used_IN && SrcB_IN != 0 && eff_cnt(int'(SrcB_IN)) > 0) hz = 1'b1;
    if (RegWrite_IN && Dest_IN != 0 && eff_cnt(int'(Dest_IN)) >= CNT_MAX) hz = 1'b1;
    if (m_issue) return 1'b1;
    if (m_drain || m_bub > 0) return 1'b0;
    return Instr_Valid_IN && !hz && !Serialize_IN && !Flush_IN;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_uf = 0; m_sys = 0; m_drain = 0; m_issue = 0; m_bub = 0;
  endtask

  task automatic model_edge(input bit d);
    int pe;
    bit nsys;
    bit inc, ret;
    int dr, wr;
    if (!RESET) begin
      model_reset();
      return;
    end
    pe = 0;
    for (int r = 1; r < 32; r++) pe += eff_cnt(r);
    nsys = m_issue;
    if (m_issue) begin
      m_issue = 0;
      m_bub = int'(HOLD);
    end else if (m_bub > 0) begin
      m_bub--;
    end else if (m_drain) begin
      if (Flush_IN) m_drain = 0;
      else if (pe == 0) begin m_drain = 0; m_issue = 1; end
    end else if (Instr_Valid_IN && Serialize_IN && !Flush_IN) begin
      m_drain = 1;
    end
    m_sys = nsys;
    inc = d && RegWrite_IN && Dest_IN != 0;
    ret = RegWrite1_IN && WriteRegister1_IN != 0;
    dr = int'(Dest_IN);
    wr = int'(WriteRegister1_IN);
    if (!(inc && ret && dr == wr)) begin
      if (inc) m_cnt[dr]++;
      if (ret) begin
        if (m_cnt[wr] == 0) m_uf = 1;
        else m_cnt[wr]--;
      end
    end
  endtask

  // Compare every output against the model, away from the active edge.
  task automatic settle();
    @(negedge CLK);
    e_disp = exp_dispatch();
    chk("m_disp", 32'(Dispatch_OUT), 32'(e_disp));
    chk("m_freeze", 32'(WANT_FREEZE), 32'(Instr_Valid_IN && !e_disp && !Flush_IN));
    chk("m_sys", 32'(SYS), 32'(m_sys));
    chk("m_pend", 32'(Pending_Count_OUT), 32'(m_pending()));
    chk("m_busy", Busy_Mask_OUT, m_busy());
    chk("m_uf", 32'(Underflow_ERR), 32'(m_uf));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(e_disp);
    cyc++;
    #1;
  endtask

  initial begin
    vin_t idle, plain, s;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    plain = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = row(mk(1, 0, 0, 0, 0, 5, 1, 0, 0), 1, 0, 0, 32'h0);
    tbl[1]  = row(mk(1, 5, 1, 0, 0, 6, 1, 0, 0), 0, 1, 1, 32'h20);
    tbl[2]  = row(mk(1, 5, 1, 0, 0, 0, 0, 5, 1), BYP, !BYP, 1, 32'h20);
    tbl[3]  = row(mk(1, 5, 1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h0);
    tbl[4]  = row(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 1, 0, 0, 32'h0);
    tbl[5]  = row(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 1, 0, 1, 32'h80);
    tbl[6]  = row(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 1, 0, 2, 32'h80);
    tbl[7]  = row(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 0, 1, 3, 32'h80);
    tbl[8]  = row(idle, 0, 0, 3, 32'h80);
    tbl[9]  = row(mk(1, 0, 1, 0, 1, 0, 1, 0, 0), 1, 0, 3, 32'h80);
    tbl[10] = row(mk(0, 0, 0, 0, 0, 0, 0, 7, 1), 0, 0, 3, 32'h80);
    tbl[11] = row(mk(0, 0, 0, 0, 0, 0, 0, 7, 1), 0, 0, 2, 32'h80);
    tbl[12] = row(mk(0, 0, 0, 0, 0, 0, 0, 7, 1), 0, 0, 1, 32'h80);
    tbl[13] = row(idle, 0, 0, 0, 32'h0);
    tbl[14] = row(mk(1, 0, 0, 0, 0, 3, 1, 0, 0), 1, 0, 0, 32'h0);
    tbl[15] = row(mk(1, 0, 0, 0, 0, 3, 1, 3, 1), 1, 0, 1, 32'h8);
    tbl[16] = row(idle, 0, 0, 1, 32'h8);
    tbl[17] = row(mk(0, 0, 0, 0, 0, 0, 0, 3, 1), 0, 0, 1, 32'h8);
    tbl[18] = row(idle, 0, 0, 0, 32'h0);

    // Reset
    RESET = 1'b0;
    apply(idle);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    settle();
    chk("rst_sys", 32'(SYS), 32'h0);
    chk("rst_pend", 32'(Pending_Count_OUT), 32'h0);
    chk("rst_busy", Busy_Mask_OUT, 32'h0);
    chk("rst_uf", 32'(Underflow_ERR), 32'h0);
    tick();
    RESET = 1'b1;

    // Producer/consumer, saturation, r0, simultaneous inc/dec
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].in);
      settle();
      chk($sformatf("tbl%0d_disp", i), 32'(Dispatch_OUT), 32'(tbl[i].e_disp));
      chk($sformatf("tbl%0d_frz", i), 32'(WANT_FREEZE), 32'(tbl[i].e_frz));
      chk($sformatf("tbl%0d_pend", i), 32'(Pending_Count_OUT), 32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_busy", i), Busy_Mask_OUT, tbl[i].e_busy);
      tick();
    end

    // Underflow on r9, sticky
    apply(mk(0, 0, 0, 0, 0, 0, 0, 9, 1));
    settle();
    chk("uf_before", 32'(Underflow_ERR), 32'h0);
    tick();
    apply(idle);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("uf_sticky%0d", k), 32'(Underflow_ERR), 32'h1);
      chk($sformatf("uf_pend%0d", k), 32'(Pending_Count_OUT), 32'h0);
      tick();
    end

    // Serialize with two writes in flight
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 0)); settle(); tick();
    apply(mk(1, 0, 0, 0, 0, 2, 1, 0, 0)); settle(); tick();
    for (int i = 0; i < 8; i++) begin
      vin_t v;
      if (i <= ISSUE_IDX) begin
        v = plain;
        v.ser = 1'b1;
      end else begin
        v = plain;
      end
      if (i == 1) begin v.wr = 5'd1; v.rwr = 1'b1; end
      if (i == 2) begin v.wr = 5'd2; v.rwr = 1'b1; end
      apply(v);
      settle();
      chk($sformatf("ser%0d_disp", i), 32'(Dispatch_OUT),
          32'((i == ISSUE_IDX) || (i >= ISSUE_IDX + int'(HOLD) + 1)));
      chk($sformatf("ser%0d_sys", i), 32'(SYS), 32'(i == ISSUE_IDX + 1));
      tick();
    end

    // Flush during drain
    apply(mk(1, 0, 0, 0, 0, 4, 1, 0, 0)); settle(); tick();
    s = plain; s.ser = 1'b1;
    apply(s); settle();
    chk("fl0_disp", 32'(Dispatch_OUT), 32'h0);
    chk("fl0_frz", 32'(WANT_FREEZE), 32'h1);
    tick();
    s.fl = 1'b1;
    apply(s); settle();
    chk("fl1_disp", 32'(Dispatch_OUT), 32'h0);
    chk("fl1_frz", 32'(WANT_FREEZE), 32'h0);
    tick();
    apply(plain); settle();
    chk("fl2_disp", 32'(Dispatch_OUT), 32'h1);
    chk("fl2_sys", 32'(SYS), 32'h0);
    chk("fl2_pend", 32'(Pending_Count_OUT), 32'h1);
    chk("fl2_busy", Busy_Mask_OUT, 32'h10);
    tick();
    apply(idle); settle();
    chk("fl3_sys", 32'(SYS), 32'h0);
    tick();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 4, 1)); settle(); tick();

    // Reset asserted during the hold bubble
    s = mk(1, 0, 0, 0, 0, 8, 1, 0, 0); s.ser = 1'b1;
    apply(s); settle(); tick();
    apply(s); settle(); tick();
    apply(s); settle();
    chk("rh_issue", 32'(Dispatch_OUT), 32'h1);
    tick();
    apply(idle);
    RESET = 1'b0;
    settle();
    chk("rh_sys_hi", 32'(SYS), 32'h1);
    chk("rh_pend_hi", 32'(Pending_Count_OUT), 32'h1);
    tick();
    RESET = 1'b1;
    apply(plain);
    settle();
    chk("rh_sys", 32'(SYS), 32'h0);
    chk("rh_pend", 32'(Pending_Count_OUT), 32'h0);
    chk("rh_busy", Busy_Mask_OUT, 32'h0);
    chk("rh_uf", 32'(Underflow_ERR), 32'h0);
    chk("rh_disp", 32'(Dispatch_OUT), 32'h1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      vin_t v;
      int pick;
      v.valid = ($urandom_range(0, 9) < 8);
      v.sa  = 5'($urandom_range(0, 7));
      v.sau = 1'($urandom_range(0, 1));
      v.sb  = 5'($urandom_range(0, 7));
      v.sbu = 1'($urandom_range(0, 1));
      v.dst = 5'($urandom_range(0, 7));
      v.rw  = 1'($urandom_range(0, 1));
      v.ser = ($urandom_range(0, 29) == 0);
      v.fl  = ($urandom_range(0, 9) == 0);
      v.wr  = 5'd0;
      v.rwr = 1'b0;
      pick = int'($urandom_range(0, 99));
      if (pick < 45) begin
        int q[$];
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r);
        if (q.size() > 0) begin
          v.wr  = 5'(q[$urandom_range(0, q.size() - 1)]);
          v.rwr = 1'b1;
        end
      end else if (pick < 47) begin
        v.wr  = 5'($urandom_range(0, 31));
        v.rwr = 1'b1;
      end
      RESET = ($urandom_range(0, 299) != 0);
      apply(v);
      settle();
      tick();
    end
    RESET = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
